// File: rtl/prog_loader.sv
// Instruction-RAM loader: writes one word per wr_key rising edge while in LOAD,
// then sequences the read address over the loaded words on step_key edges in RUN.
module prog_loader #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              CLOCK_50M,
  input  logic              Resetn,
  input  logic              load_en,
  input  logic              run_en,
  input  logic              wr_key,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              step_key,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              loading,
  output logic              running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic              wr_prev;
  logic              step_prev;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_edge;
  logic              step_edge;
  logic              rd_last;

  // Key inputs are levels; an event is a rising edge against last cycle's level.
  assign wr_edge   = wr_key & ~wr_prev;
  assign step_edge = step_key & ~step_prev;
  assign rd_last   = ({1'b0, rd_ptr} == (word_count - 1'b1));

  always_ff @(posedge CLOCK_50M) begin
    if (!Resetn) begin
      state      <= IDLE;
      wr_prev    <= 1'b1;
      step_prev  <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      full       <= 1'b0;
      loading    <= 1'b0;
      running    <= 1'b0;
    end else begin
      wr_prev   <= wr_key;
      step_prev <= step_key;
      mem_we    <= 1'b0;
      case (state)
        IDLE: begin
          if (load_en) begin
            state      <= LOAD;
            loading    <= 1'b1;
            wr_ptr     <= '0;
            word_count <= '0;
            full       <= 1'b0;
            mem_addr   <= '0;
          end else if (run_en && (word_count != '0)) begin
            state    <= RUN;
            running  <= 1'b1;
            rd_ptr   <= '0;
            mem_addr <= '0;
          end
        end
        LOAD: begin
          // Dropping load_en takes priority; a coincident key edge is lost.
          if (!load_en) begin
            state   <= IDLE;
            loading <= 1'b0;
          end else if (wr_edge && !full) begin
            mem_we     <= 1'b1;
            mem_addr   <= wr_ptr;
            mem_wdata  <= wr_data;
            wr_ptr     <= wr_ptr + 1'b1;
            word_count <= word_count + 1'b1;
            full       <= ((word_count + 1'b1) == FULL_CNT);
          end
        end
        RUN: begin
          if (!run_en || load_en) begin
            state    <= IDLE;
            running  <= 1'b0;
            rd_ptr   <= '0;
            mem_addr <= '0;
          end else if (step_edge) begin
            rd_ptr   <= rd_last ? '0 : rd_ptr + 1'b1;
            mem_addr <= rd_last ? '0 : rd_ptr + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          loading <= 1'b0;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed scenarios plus random traffic, all outputs
// checked each cycle against a program-queue model of the loader.
module tb_prog_loader;

  localparam int DATA_W = 10;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int W      = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              Resetn;
  logic              load_en;
  logic              run_en;
  logic              wr_key;
  logic [DATA_W-1:0] wr_data;
  logic              step_key;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              full;
  logic              loading;
  logic              running;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected writes {addr, data} for directed phases.
  logic [W-1:0] exp_q[$];

  prog_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLOCK_50M (clk),
    .Resetn    (Resetn),
    .load_en   (load_en),
    .run_en    (run_en),
    .wr_key    (wr_key),
    .wr_data   (wr_data),
    .step_key  (step_key),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .word_count(word_count),
    .full      (full),
    .loading   (loading),
    .running   (running)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 loading, 2 running. The loaded program is a queue, so
  // word_count is its size and the next write address is its size.
  int                m_mode;
  logic [DATA_W-1:0] prog[$];
  int                m_rd;
  bit                m_we;
  int                m_addr;
  int                m_wdata;
  bit                m_wprev, m_sprev;
  bit                m_valid = 0;
  bit                m_just_reset;

  always @(posedge clk) begin
    bit wedge, sedge;
    if (!Resetn) begin
      m_mode = 0; prog.delete(); m_rd = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      m_wprev = 1; m_sprev = 1; m_valid = 1; m_just_reset = 1;
    end else if (m_valid) begin
      m_just_reset = 0;
      wedge = wr_key && !m_wprev;
      sedge = step_key && !m_sprev;
      m_wprev = wr_key;
      m_sprev = step_key;
      m_we = 0;
      case (m_mode)
        0: begin
          if (load_en) begin
            m_mode = 1; prog.delete(); m_addr = 0;
          end else if (run_en && prog.size() > 0) begin
            m_mode = 2; m_rd = 0; m_addr = 0;
          end
        end
        1: begin
          if (!load_en) m_mode = 0;
          else if (wedge && prog.size() < DEPTH) begin
            m_we = 1; m_addr = prog.size(); m_wdata = wr_data;
            prog.push_back(wr_data);
          end
        end
        default: begin
          if (!run_en || load_en) begin
            m_mode = 0; m_rd = 0; m_addr = 0;
          end else if (sedge) begin
            m_rd = (m_rd + 1) % prog.size();
            m_addr = m_rd;
          end
        end
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk("mem_we", mem_we, m_we);
      chk("word_count", word_count, prog.size());
      chk("full", full, prog.size() == DEPTH);
      chk("loading", loading, m_mode == 1);
      chk("running", running, m_mode == 2);
      if (m_we || m_mode == 2 || m_just_reset) chk("mem_addr", mem_addr, m_addr);
      if (m_we || m_just_reset) chk("mem_wdata", mem_wdata, m_wdata);
      if (mem_we && exp_q.size() > 0) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("sb_addr", mem_addr, e[W-1:DATA_W]);
        chk("sb_data", mem_wdata, e[DATA_W-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press_wr(input logic [DATA_W-1:0] d, input bit expect_we);
    wr_data = d;
    wr_key  = 1'b1;
    tick();
    chk("we_pulse", mem_we, expect_we);
    wr_key = 1'b0;
    tick();
    chk("we_single", mem_we, 0);
  endtask

  task automatic press_step(input int exp_addr);
    step_key = 1'b1;
    tick();
    chk("step_addr", mem_addr, exp_addr);
    step_key = 1'b0;
    tick();
    chk("step_hold", mem_addr, exp_addr);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seq[5];
    logic [DATA_W-1:0] d;
    seq = '{1, 2, 0, 1, 2};
    Resetn = 1'b0; load_en = 1'b0; run_en = 1'b0;
    wr_key = 1'b1; wr_data = '0; step_key = 1'b0;

    // 1: key held high through reset produces no write
    tick(); tick();
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_count", word_count, 0);
    chk("rst_state", {loading, running}, 0);
    Resetn = 1'b1;
    load_en = 1'b1;
    tick();
    repeat (3) begin
      tick();
      chk("held_key_no_we", mem_we, 0);
    end
    chk("held_key_loading", loading, 1);
    chk("held_key_count", word_count, 0);
    wr_key = 1'b0;
    tick();

    // 2: three writes
    exp_q.push_back({5'd0, 10'h1A0});
    exp_q.push_back({5'd1, 10'h0C3});
    exp_q.push_back({5'd2, 10'h3FF});
    press_wr(10'h1A0, 1);
    press_wr(10'h0C3, 1);
    press_wr(10'h3FF, 1);
    chk("load3_count", word_count, 3);
    chk("model_count3", prog.size(), 3);
    chk("model_prog2", prog[2], 10'h3FF);

    // 4: run over three words
    load_en = 1'b0; tick();
    run_en = 1'b1; tick();
    chk("run_enter_addr", mem_addr, 0);
    chk("run_enter_running", running, 1);
    for (int i = 0; i < 5; i++) press_step(seq[i]);
    run_en = 1'b0; tick();
    chk("run_exit", running, 0);

    // 3: fill to 32, 33rd edge ignored
    load_en = 1'b1; tick();
    chk("reload_clear", word_count, 0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      d = DATA_W'($urandom_range(0, 1023));
      if (i < DEPTH) exp_q.push_back({ADDR_W'(i), d});
      press_wr(d, i < DEPTH);
      if (i == DEPTH - 2) chk("not_full_31", full, 0);
      if (i == DEPTH - 1) chk("full_at_32", full, 1);
    end
    chk("full_count", word_count, DEPTH);
    load_en = 1'b0; tick();
    run_en = 1'b1; tick();
    for (int i = 1; i <= DEPTH + 2; i++) press_step(i % DEPTH);
    run_en = 1'b0; tick();

    // 5: load_en falls with a key edge in the same cycle
    load_en = 1'b1; tick();
    wr_key = 1'b1; load_en = 1'b0; tick();
    chk("drop_edge_we", mem_we, 0);
    chk("drop_edge_state", loading, 0);
    chk("drop_edge_count", word_count, 0);
    wr_key = 1'b0; run_en = 1'b1; tick(); tick();
    chk("run_empty_ignored", running, 0);
    run_en = 1'b0; tick();

    // 6: reset in RUN, then a fresh load starts at address 0
    load_en = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      d = DATA_W'($urandom_range(0, 1023));
      exp_q.push_back({ADDR_W'(i), d});
      press_wr(d, 1);
    end
    load_en = 1'b0; tick();
    run_en = 1'b1; tick();
    press_step(1);
    press_step(2);
    Resetn = 1'b0; tick();
    chk("rst_run_addr", mem_addr, 0);
    chk("rst_run_count", word_count, 0);
    chk("rst_run_state", {loading, running}, 0);
    chk("rst_run_we", mem_we, 0);
    Resetn = 1'b1; run_en = 1'b0; load_en = 1'b1; tick();
    exp_q.push_back({5'd0, 10'h155});
    press_wr(10'h155, 1);
    load_en = 1'b0; tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) load_en = ~load_en;
      if ($urandom_range(0, 29) == 0) run_en = ~run_en;
      wr_key   = 1'($urandom_range(0, 1));
      step_key = 1'($urandom_range(0, 1));
      wr_data  = DATA_W'($urandom_range(0, 1023));
      Resetn   = ($urandom_range(0, 599) != 0);
      tick();
    end
    Resetn = 1'b1; load_en = 1'b0; run_en = 1'b0;
    tick(); tick();
    chk("exp_q_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Write-side companion to the instruction memory: fills the 32x10 instruction RAM from board inputs before the processor runs.
- While loading, it is the memory's writer. In run mode it becomes the read-address sequencer, stepping the RAM address on each memory-clock pulse and wrapping over only the words actually loaded.
- Sits between the debounced key flags / switches and the RAM address, data and write-enable pins.

Parameters:
- DATA_W, 10, instruction word width (matches DIN/Bus)
- ADDR_W, 5, RAM address width
- DEPTH, 32, number of RAM words; must equal 2**ADDR_W

Ports:
- CLOCK_50M  input  1  system clock; all logic on its rising edge
- Resetn  input  1  synchronous reset, active low
- load_en  input  1  level; 1 requests load mode
- run_en  input  1  level; 1 requests run (read-sequencing) mode
- wr_key  input  1  debounced key level; each rising edge writes one word
- wr_data  input  DATA_W  word to write (from switches)
- step_key  input  1  debounced memory-clock level; each rising edge advances the read address
- mem_we  output  1  RAM write enable, one-cycle pulse
- mem_addr  output  ADDR_W  RAM address (write address in LOAD, read address in RUN)
- mem_wdata  output  DATA_W  RAM write data
- word_count  output  ADDR_W+1  words loaded, 0..DEPTH
- full  output  1  word_count == DEPTH
- loading  output  1  state == LOAD
- running  output  1  state == RUN

Behaviour:
- All outputs are registered.
- Reset (Resetn=0 at a clock edge), next cycle: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, word_count=0, full=0, loading=0, running=0, write pointer=0, read pointer=0.
  - Both edge-detect history registers reset to 1, so a key held high through reset produces no edge.
- Edge detect: an edge is (key==1 && prev==0). prev updates every cycle. Edges are evaluated only in the state that uses them; edges in other states are discarded.
- States: IDLE=0, LOAD=1, RUN=2. Encoding 3 is illegal and goes to IDLE on the next edge.
- IDLE:
  - load_en=1 -> LOAD; clear write pointer and word_count (a new load replaces the previous program).
  - Else run_en=1 and word_count>0 -> RUN; read pointer=0.
  - load_en has priority over run_en.
  - run_en with word_count=0 is ignored; stay IDLE.
- LOAD:
  - load_en=0 -> IDLE. This wins over a same-cycle wr_key edge, and that edge is dropped.
  - wr_key edge and word_count<DEPTH, sampled at edge n:
    - at edge n+1: mem_we=1, mem_addr=write pointer, mem_wdata=wr_data as sampled at edge n.
    - write pointer and word_count increment at the same edge.
  - mem_we is high for exactly one cycle per accepted edge.
  - wr_key edge while full=1: ignored, no write.
  - The write pointer wraps to 0 after DEPTH-1, but writes stop at full, so this wrap is never used.
  - run_en is ignored in LOAD.
- RUN:
  - mem_addr = read pointer.
  - step_key edge: read pointer = (read pointer == word_count-1) ? 0 : read pointer+1. mem_addr shows the new value one cycle after the edge is sampled.
  - When word_count=DEPTH, wrap is from 31 to 0.
  - run_en=0 or load_en=1 -> IDLE. The read pointer clears to 0 and any step edge in that cycle is dropped.
- mem_we is 0 in every state except the single post-edge cycle in LOAD.
- word_count and the loaded RAM contents persist across IDLE/RUN; only reset or re-entering LOAD clears word_count.
- Reset mid-write (same edge as a pending mem_we): reset wins, mem_we=0.

Test Plan:
1. Reset with wr_key=1 held, release Resetn, load_en=1, keep wr_key=1 -> no mem_we, word_count=0, loading=1.
2. LOAD: 3 wr_key edges with wr_data 0x1A0, 0x0C3, 0x3FF -> three single-cycle mem_we pulses at addr 0, 1, 2 with those data, each one cycle after its edge; word_count=3.
3. Load 32 edges, then a 33rd edge -> writes at 0..31, full=1 after the 32nd, no mem_we on the 33rd, word_count=32.
4. word_count=3, load_en=0, run_en=1, then 5 step_key edges -> mem_addr sequence 0,1,2,0,1,2; running=1.
5. Same-cycle wr_key edge and load_en falling in LOAD -> no write, state IDLE next cycle, word_count unchanged; then run_en=1 with word_count=0 -> stays IDLE.
6. In RUN at mem_addr=2, pulse Resetn=0 for one cycle -> next cycle all outputs 0 and state IDLE; a following load_en=1 restarts writing at addr 0.
